// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces an optical gate, measures
// the occlusion width and turns it into Rs. 5 / Rs. 10 credit or reject.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned W5_MIN   = 10,
    parameter int unsigned W10_MIN  = 20,
    parameter int unsigned W10_MAX  = 39,
    parameter int unsigned GAP      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_sense,
    input  logic accept_en,
    output logic coin_5,
    output logic coin_10,
    output logic reject,
    output logic jam,
    output logic busy
);

    localparam int unsigned DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    // Low samples needed in ARM: longer than the synchronizer depth, so a
    // sensor held high across reset is seen before IDLE can be entered.
    localparam int unsigned ARM_N = 3;

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        MEASURE,
        CLASSIFY,
        JAM,
        LOCKOUT
    } state_t;

    logic           s1_q, s2_q;
    logic           filt_q, filt_d;
    logic [DBW-1:0] dcnt_q, dcnt_d;
    state_t         state_q;
    logic [7:0]     wcnt_q;
    logic [7:0]     lcnt_q;
    logic           c5_q, c10_q, rej_q, jam_q, busy_q;

    // Two-flop synchronizer for the asynchronous gate sensor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= coin_sense;
            s2_q <= s1_q;
        end
    end

    // Filtered level follows the synced level after DEBOUNCE agreeing samples.
    always_comb begin
        filt_d = filt_q;
        dcnt_d = '0;
        if (s2_q != filt_q) begin
            if (dcnt_q == DBW'(DEBOUNCE - 1)) begin
                filt_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Debouncer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
            dcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            dcnt_q <= dcnt_d;
        end
    end

    // Control FSM with registered outputs; tracks filt_d so that MEASURE
    // spans exactly the cycles in which the filtered level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
            wcnt_q  <= 8'd0;
            lcnt_q  <= 8'd0;
            c5_q    <= 1'b0;
            c10_q   <= 1'b0;
            rej_q   <= 1'b0;
            jam_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            c5_q  <= 1'b0;
            c10_q <= 1'b0;
            rej_q <= 1'b0;
            unique case (state_q)
                ARM: begin
                    if (s2_q || filt_q) begin
                        lcnt_q <= 8'd0;
                    end else if (lcnt_q == 8'(ARM_N - 1)) begin
                        lcnt_q  <= 8'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        lcnt_q <= lcnt_q + 8'd1;
                    end
                end
                IDLE: begin
                    if (filt_d) begin
                        state_q <= MEASURE;
                        wcnt_q  <= 8'd1;
                        busy_q  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!filt_d) begin
                        state_q <= CLASSIFY;
                    end else begin
                        if (wcnt_q != 8'hFF) begin
                            wcnt_q <= wcnt_q + 8'd1;
                        end
                        if (wcnt_q == 8'(W10_MAX)) begin
                            state_q <= JAM;
                            jam_q   <= 1'b1;
                            rej_q   <= 1'b1;
                        end
                    end
                end
                CLASSIFY: begin
                    state_q <= LOCKOUT;
                    lcnt_q  <= 8'd0;
                    if (accept_en && wcnt_q >= 8'(W5_MIN)
                        && wcnt_q < 8'(W10_MIN)) begin
                        c5_q <= 1'b1;
                    end else if (accept_en && wcnt_q >= 8'(W10_MIN)
                        && wcnt_q <= 8'(W10_MAX)) begin
                        c10_q <= 1'b1;
                    end else begin
                        rej_q <= 1'b1;
                    end
                end
                JAM: begin
                    if (!filt_d) begin
                        state_q <= LOCKOUT;
                        lcnt_q  <= 8'd0;
                        jam_q   <= 1'b0;
                    end else if (wcnt_q != 8'hFF) begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                LOCKOUT: begin
                    if (lcnt_q == 8'(GAP - 1)) begin
                        lcnt_q <= 8'd0;
                        if (filt_d) begin
                            state_q <= ARM;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        lcnt_q <= lcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ARM;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign coin_5  = c5_q;
    assign coin_10 = c10_q;
    assign reject  = rej_q;
    assign jam     = jam_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed and random coins scored against
// a width/latency model derived from the acceptor's behaviour rules.
module tb_coin_acceptor;

    localparam int DB  = 3;
    localparam int W5  = 10;
    localparam int W10 = 20;
    localparam int WMX = 39;
    localparam int GP  = 8;

    logic clk = 1'b0;
    logic reset;
    logic coin_sense;
    logic accept_en;
    logic coin_5, coin_10, reject, jam, busy;

    int checks = 0;
    int errors = 0;
    logic [4:0] obs [512];
    int olen;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEBOUNCE(DB), .W5_MIN(W5), .W10_MIN(W10),
        .W10_MAX(WMX), .GAP(GP)
    ) dut (
        .clk(clk), .reset(reset), .coin_sense(coin_sense),
        .accept_en(accept_en), .coin_5(coin_5), .coin_10(coin_10),
        .reject(reject), .jam(jam), .busy(busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Record outputs of cycle k, then drive inputs sampled at its end.
    task automatic run_seq(input int a1, input int n1, input int a2,
                           input int n2, input bit acc, input int hold,
                           input int len);
        olen = len;
        for (int k = 0; k < len; k++) begin
            obs[k] = {busy, jam, reject, coin_10, coin_5};
            coin_sense = (k >= a1 && k < a1 + n1) ||
                         (k >= a2 && k < a2 + n2);
            accept_en = (k <= hold) ? acc : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    function automatic int cnt(input int b);
        int c = 0;
        for (int k = 0; k < olen; k++) c += int'(obs[k][b]);
        return c;
    endfunction

    function automatic int first_at(input int b);
        for (int k = 0; k < olen; k++) if (obs[k][b]) return k;
        return -1;
    endfunction

    function automatic int pulse_rule_violations();
        int v = 0;
        int p;
        for (int k = 0; k < olen; k++) begin
            p = int'(obs[k][0]) + int'(obs[k][1]) + int'(obs[k][2]);
            if (p > 1) v++;
            if (k > 0 && p > 0 && (|obs[k-1][2:0])) v++;
        end
        return v;
    endfunction

    // 0 none, 1 Rs.5, 2 Rs.10, 3 reject, 4 jam
    function automatic int model_kind(input int n, input bit acc);
        if (n < DB) return 0;
        if (n > WMX) return 4;
        if (acc && n >= W5 && n < W10) return 1;
        if (acc && n >= W10) return 2;
        return 3;
    endfunction

    task automatic run_coin(input int n, input bit acc);
        int lat, rise, fall, pulse, jam_at, idle_at, kind, len;
        string t;
        lat = 2 + DB;
        rise = lat;
        fall = n + lat;
        pulse = fall + 1;
        jam_at = lat + WMX;
        kind = model_kind(n, acc);
        idle_at = (kind == 4) ? fall + GP : pulse + GP;
        len = n + lat + GP + 8;
        run_seq(0, n, 0, 0, acc, pulse, len);
        t = $sformatf("w%0d_a%0d", n, acc);
        check({t, "_c5"}, cnt(0), (kind == 1) ? 1 : 0);
        check({t, "_c10"}, cnt(1), (kind == 2) ? 1 : 0);
        check({t, "_rej"}, cnt(2), (kind >= 3) ? 1 : 0);
        check({t, "_excl"}, pulse_rule_violations(), 0);
        if (kind == 1) check({t, "_c5_at"}, first_at(0), pulse);
        if (kind == 2) check({t, "_c10_at"}, first_at(1), pulse);
        if (kind == 3) check({t, "_rej_at"}, first_at(2), pulse);
        if (kind == 4) begin
            check({t, "_jam_at"}, first_at(3), jam_at);
            check({t, "_jam_len"}, cnt(3), n - WMX);
            check({t, "_jrej_at"}, first_at(2), jam_at);
        end else begin
            check({t, "_nojam"}, cnt(3), 0);
        end
        if (kind == 0) begin
            check({t, "_nobusy"}, cnt(4), 0);
        end else begin
            check({t, "_busy_at"}, first_at(4), rise);
            check({t, "_busy_len"}, cnt(4), idle_at - rise);
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, int'(busy), 0);
    endtask

    int rn;
    bit ra;

    initial begin
        reset = 1'b0;
        coin_sense = 1'b0;
        accept_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_c5", int'(coin_5), 0);
        check("rst_c10", int'(coin_10), 0);
        check("rst_rej", int'(reject), 0);
        check("rst_jam", int'(jam), 0);
        check("rst_busy", int'(busy), 1);
        reset = 1'b1;
        wait_idle("startup_idle", 20);

        run_coin(15, 1'b1);
        run_coin(25, 1'b1);
        run_coin(25, 1'b0);
        run_coin(9, 1'b1);
        run_coin(10, 1'b1);
        run_coin(19, 1'b1);
        run_coin(20, 1'b1);
        run_coin(39, 1'b1);
        run_coin(40, 1'b1);
        run_coin(60, 1'b1);
        run_coin(1, 1'b1);
        run_coin(2, 1'b1);
        run_coin(12, 1'b0);

        // second coin 3 cycles after the first credit: ignored, then ARM
        run_seq(0, 15, 24, 12, 1'b1, 200, 80);
        check("dbl_c5", cnt(0), 1);
        check("dbl_c5_at", first_at(0), 15 + 2 + DB + 1);
        check("dbl_c10", cnt(1), 0);
        check("dbl_rej", cnt(2), 0);
        check("dbl_jam", cnt(3), 0);
        check("dbl_busy_mid", int'(obs[40][4]), 1);
        check("dbl_idle_end", int'(obs[79][4]), 0);
        run_coin(15, 1'b1);

        // reset mid-measure with sensor still high at release
        run_seq(0, 200, 0, 0, 1'b1, 200, 12);
        check("mid_busy", int'(obs[11][4]), 1);
        reset = 1'b0;
        #1;
        check("arst_c5", int'(coin_5), 0);
        check("arst_c10", int'(coin_10), 0);
        check("arst_rej", int'(reject), 0);
        check("arst_jam", int'(jam), 0);
        check("arst_busy", int'(busy), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_seq(0, 30, 0, 0, 1'b1, 200, 60);
        check("post_c5", cnt(0), 0);
        check("post_c10", cnt(1), 0);
        check("post_rej", cnt(2), 0);
        check("post_jam", cnt(3), 0);
        check("post_arm", int'(obs[20][4]), 1);
        wait_idle("post_idle", 40);
        run_coin(25, 1'b1);

        for (int i = 0; i < 16; i++) begin
            rn = int'($urandom_range(1, 70));
            ra = 1'($urandom_range(0, 1));
            run_coin(rn, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive identical synchronized samples required to change the filtered sensor level.
REQ-002 Parameter W5_MIN, default 10: minimum filtered high width, in cycles, credited as Rs. 5.
REQ-003 Parameter W10_MIN, default 20: minimum width credited as Rs. 10. Widths W5_MIN..W10_MIN-1 credit Rs. 5.
REQ-004 Parameter W10_MAX, default 39: maximum width credited as Rs. 10. Width W10_MAX+1 declares a jam.
REQ-005 Parameter GAP, default 8: lockout cycles after every coin event.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 coin_sense  input  1  raw optical-gate sensor, asynchronous; high while a coin occludes the gate.
REQ-009 accept_en  input  1  the vending machine can take credit. Sampled only in CLASSIFY.
REQ-010 coin_5  output  1  single-cycle Rs. 5 credit pulse to the vending machine.
REQ-011 coin_10  output  1  single-cycle Rs. 10 credit pulse to the vending machine.
REQ-012 reject  output  1  single-cycle pulse: invalid width or credit refused; the coin is diverted to the return chute.
REQ-013 jam  output  1  level: the gate has stayed occluded beyond W10_MAX.
REQ-014 busy  output  1  level: high whenever the state is not IDLE.

Function
REQ-015 coin_sense passes through a 2-flop synchronizer before any other use.
REQ-016 Debouncer: the filtered level takes the synchronized value once that value has differed from the filtered level for DEBOUNCE consecutive cycles. Any shorter glitch is ignored and restarts the count.
REQ-017 States are ARM, IDLE, MEASURE, CLASSIFY, JAM, LOCKOUT.
- ARM: wait for filtered low, then go to IDLE.
- IDLE: on filtered rise, go to MEASURE with the width counter at 1.
- MEASURE: the counter increments once per cycle while filtered is high. On filtered fall, go to CLASSIFY. When the counter reaches W10_MAX+1, go to JAM.
- CLASSIFY: one cycle, then go to LOCKOUT.
- JAM: when filtered is low, go to LOCKOUT.
- LOCKOUT: lasts GAP cycles, then go to IDLE.
REQ-018 The width counter is 8 bits wide and saturates at 255. Its value is the number of cycles the filtered level was high.
REQ-019 CLASSIFY asserts exactly one output for exactly that cycle:
- coin_5 if W5_MIN <= width < W10_MIN and accept_en = 1;
- coin_10 if W10_MIN <= width <= W10_MAX and accept_en = 1;
- reject otherwise, including a valid width with accept_en = 0.
REQ-020 Latency: the credit or reject pulse occurs in the cycle immediately after the filtered level falls.
REQ-021 coin_5, coin_10 and reject are mutually exclusive and are never high for two consecutive cycles.
REQ-022 Entry into JAM raises jam and pulses reject once in the entry cycle. jam stays high until the state leaves JAM.
REQ-023 A filtered rise during LOCKOUT is not measured. If that rise is still high when LOCKOUT ends, the FSM goes to ARM instead of IDLE.
REQ-024 Changes on accept_en outside CLASSIFY have no effect.

Reset
REQ-025 While reset = 0, the following hold asynchronously:
- state = ARM;
- synchronizer flops, filtered level and all counters are 0;
- coin_5, coin_10, reject and jam are 0;
- busy is 1.
REQ-026 Reset asserted mid-MEASURE discards the coin; no pulse is issued for it.
REQ-027 After reset release, a coin is counted only after the filtered level has been observed low at least once. A sensor held high through reset release therefore produces no credit.

Verification
REQ-028 coin_sense high for 15 cycles, accept_en = 1 -> one coin_5 pulse one cycle after the filtered fall; busy for the next 8 cycles, then idle.
REQ-029 coin_sense high for 25 cycles, accept_en = 1 -> one coin_10 pulse. Repeat with accept_en = 0 -> one reject pulse and no credit.
REQ-030 Boundary widths, accept_en = 1:
- 9 cycles -> reject;
- 10 cycles -> coin_5;
- 19 cycles -> coin_5;
- 20 cycles -> coin_10;
- 39 cycles -> coin_10.
REQ-031 coin_sense high for 60 cycles -> reject pulse and jam rising when the width counter hits 40; jam stays high until the filtered fall, then 8 cycles of LOCKOUT; no credit.
REQ-032 Glitches of 1-2 cycles on coin_sense while idle -> no state change and no outputs. A second coin starting 3 cycles after the first coin's credit -> ignored, then ARM.
REQ-033 reset low at cycle 12 of a 25-cycle coin -> all outputs 0 immediately; with coin_sense still high at release, no pulse until the sensor goes low and a fresh coin arrives.
